// File: rtl/mult_share_arbiter_pkg.sv
// Shared constants and the circular priority pick used by the multiplier-sharing arbiter.
package mult_share_pkg;

  localparam int OPW    = 4;
  localparam int PRODW  = 8;
  localparam int CNTW   = 16;
  localparam int MAXREQ = 8;
  localparam int MAXIDW = 3;
  localparam int CANDW  = MAXIDW + 1;

  typedef struct packed {
    logic              found;
    logic [MAXIDW-1:0] idx;
  } pick_t;

  // Rotate so ptr is position 0, take the first set bit, and map back to an
  // absolute index. Walking offsets high-to-low lets the lowest offset win.
  function automatic pick_t rr_pick_fn(input logic [MAXREQ-1:0] valid,
                                       input logic [MAXIDW-1:0] ptr,
                                       input int nreq);
    pick_t            res;
    logic [CANDW-1:0] cand;
    res = '0;
    for (int k = MAXREQ - 1; k >= 0; k--) begin
      if (k < nreq) begin
        cand = {1'b0, ptr} + CANDW'(k);
        if (cand >= CANDW'(nreq)) cand = cand - CANDW'(nreq);
        if (valid[cand[MAXIDW-1:0]]) begin
          res.found = 1'b1;
          res.idx   = cand[MAXIDW-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester/response bus of the multiplier-sharing arbiter; slave is the arbiter side.
interface mult_share_if
  import mult_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
);

  // Every port uses valid/ready: a transfer happens on a rising edge where both
  // are high; once valid rises, it and its payload hold until that transfer.
  logic [NREQ-1:0]     req_valid;
  logic [OPW*NREQ-1:0] req_x;
  logic [OPW*NREQ-1:0] req_y;
  logic [NREQ-1:0]     req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [PRODW-1:0]    rsp_prod;
  logic [CNTW-1:0]     ops_done;

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_prod, ops_done
  );

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_prod, ops_done
  );

endinterface

// File: rtl/main.sv
// Team 4x4 unsigned combinational multiplier core.
module main (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] o
);

  assign o = {4'b0000, x} * {4'b0000, y};

endmodule

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin winner: first valid requester at or after ptr_i, circularly.
module rr_pick
  import mult_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [ID_W-1:0] ptr_i,
  output logic [ID_W-1:0] winner_o,
  output logic            found_o
);

  logic [MAXREQ-1:0] valid_ext;
  logic [MAXIDW-1:0] ptr_ext;
  pick_t             pick;

  always_comb begin
    valid_ext             = '0;
    valid_ext[NREQ-1:0]   = valid_i;
    ptr_ext               = MAXIDW'(ptr_i);
    pick                  = rr_pick_fn(valid_ext, ptr_ext, NREQ);
    winner_o              = ID_W'(pick.idx);
    found_o               = pick.found;
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one 4x4 multiplier core: operand register -> core -> product register.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_share_if.slave     bus,
  output logic [ID_W-1:0] dbg_rr_ptr_o
);

  logic             s1_valid_q, s1_valid_d;
  logic [OPW-1:0]   s1_x_q, s1_x_d;
  logic [OPW-1:0]   s1_y_q, s1_y_d;
  logic [ID_W-1:0]  s1_id_q, s1_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [PRODW-1:0] rsp_prod_q, rsp_prod_d;
  logic [CNTW-1:0]  ops_done_q, ops_done_d;

  logic [ID_W-1:0]  winner;
  logic             found;
  logic [PRODW-1:0] core_o;
  logic             s1_adv, s2_adv, accept;
  logic [NREQ-1:0]  req_ready;

  rr_pick #(.NREQ(NREQ), .ID_W(ID_W)) u_pick (
    .valid_i  (bus.req_valid),
    .ptr_i    (rr_ptr_q),
    .winner_o (winner),
    .found_o  (found)
  );

  main u_core (
    .x (s1_x_q),
    .y (s1_y_q),
    .o (core_o)
  );

  always_comb begin
    s2_adv      = !rsp_valid_q || bus.rsp_ready;
    s1_adv      = !s1_valid_q || s2_adv;
    // found implies req_valid[winner], so the grant itself is the accept.
    accept      = found && s1_adv && rst_n;
    req_ready   = '0;
    if (accept) req_ready[winner] = 1'b1;

    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_id_d     = s1_id_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_prod_d  = rsp_prod_q;
    ops_done_d  = ops_done_q;

    if (s1_adv) s1_valid_d = accept;
    if (accept) begin
      s1_x_d   = bus.req_x[OPW*int'(winner) +: OPW];
      s1_y_d   = bus.req_y[OPW*int'(winner) +: OPW];
      s1_id_d  = winner;
      rr_ptr_d = (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;
    end

    if (s2_adv) begin
      rsp_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        rsp_prod_d = core_o;
        rsp_id_d   = s1_id_q;
      end
    end

    if (rsp_valid_q && bus.rsp_ready) ops_done_d = ops_done_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_id_q     <= '0;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_prod_q  <= '0;
      ops_done_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_id_q     <= s1_id_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_prod_q  <= rsp_prod_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_prod  = rsp_prod_q;
  assign bus.ops_done  = ops_done_q;
  assign dbg_rr_ptr_o  = rr_ptr_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed and random bench for mult_share_arbiter: per-scenario tasks plus an in-order response scoreboard.
module tb_mult_share_arbiter;
  import mult_share_pkg::*;

  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int EXPW = ID_W + PRODW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [ID_W-1:0] dbg_ptr;

  int checks = 0;
  int errors = 0;
  int exp_ops = 0;
  logic [EXPW-1:0] exp_q[$];

  mult_share_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  mult_share_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .dbg_rr_ptr_o (dbg_ptr)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // scoreboard: accepted operations are expected back in accept order
  always @(negedge clk) begin
    logic [EXPW-1:0]  head;
    logic [PRODW-1:0] p;
    if (!rst_n) begin
      exp_q.delete();
      exp_ops = 0;
    end else begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: got id=%0d prod=%0d, required no response",
                   bus.rsp_id, bus.rsp_prod);
        end else begin
          head = exp_q.pop_front();
          if ({bus.rsp_id, bus.rsp_prod} !== head) begin
            errors++;
            $display("FAIL rsp_order: got id=%0d prod=%0d, required id=%0d prod=%0d",
                     bus.rsp_id, bus.rsp_prod, head[EXPW-1:PRODW], head[PRODW-1:0]);
          end
        end
        exp_ops++;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          p = bus.req_x[4*i +: 4] * bus.req_y[4*i +: 4];
          exp_q.push_back({ID_W'(i), p});
        end
      end
      checks++;
      if ($countones(bus.req_ready) > 1) begin
        errors++;
        $display("FAIL req_ready_onehot: got %b, required at most one bit", bus.req_ready);
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called at a negedge: lets the edge happen and withdraws accepted requests.
  task automatic advance();
    logic [NREQ-1:0] acc;
    acc = bus.req_valid & bus.req_ready;
    step();
    bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic apply_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks += 4;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b, required 0", bus.rsp_valid); end
    if (bus.ops_done !== 16'd0) begin errors++; $display("FAIL reset_ops_done: got %0d, required 0", bus.ops_done); end
    if (dbg_ptr !== 2'd0) begin errors++; $display("FAIL reset_rr_ptr: got %0d, required 0", dbg_ptr); end
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b, required 0000", bus.req_ready); end
    advance();
  endtask

  task automatic test_single();
    apply_reset();
    bus.req_valid[2]   = 1'b1;
    bus.req_x[11:8]    = 4'd15;
    bus.req_y[11:8]    = 4'd15;
    bus.rsp_ready      = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b, required 0100", bus.req_ready); end
    advance();
    @(negedge clk);
    checks++;
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_latency: got rsp_valid=%b, required 0", bus.rsp_valid); end
    advance();
    @(negedge clk);
    checks += 4;
    if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b, required 1", bus.rsp_valid); end
    if (bus.rsp_id !== 2'd2) begin errors++; $display("FAIL single_rsp_id: got %0d, required 2", bus.rsp_id); end
    if (bus.rsp_prod !== 8'hE1) begin errors++; $display("FAIL single_rsp_prod: got %h, required e1", bus.rsp_prod); end
    if (bus.ops_done !== 16'd0) begin errors++; $display("FAIL single_ops_before: got %0d, required 0", bus.ops_done); end
    advance();
    @(negedge clk);
    checks += 2;
    if (bus.ops_done !== 16'd1) begin errors++; $display("FAIL single_ops_after: got %0d, required 1", bus.ops_done); end
    if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got rsp_valid=%b, required 0", bus.rsp_valid); end
    advance();
  endtask

  task automatic test_simultaneous();
    logic [NREQ-1:0]  er;
    logic [PRODW-1:0] ep;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[4*i +: 4] = 4'(i + 1);
      bus.req_y[4*i +: 4] = 4'd3;
    end
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 4) begin
        er = NREQ'(1) << c;
        checks++;
        if (bus.req_ready !== er) begin errors++; $display("FAIL simul_grant c=%0d: got %b, required %b", c, bus.req_ready, er); end
      end
      if (c >= 2) begin
        ep = PRODW'(3 * (c - 1));
        checks += 3;
        if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL simul_rsp_valid c=%0d: got %b, required 1", c, bus.rsp_valid); end
        if (bus.rsp_id !== ID_W'(c - 2)) begin errors++; $display("FAIL simul_rsp_id c=%0d: got %0d, required %0d", c, bus.rsp_id, c - 2); end
        if (bus.rsp_prod !== ep) begin errors++; $display("FAIL simul_rsp_prod c=%0d: got %0d, required %0d", c, bus.rsp_prod, ep); end
      end
      advance();
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] er;
    apply_reset();
    bus.req_x[7:4]   = 4'd7;  bus.req_y[7:4]   = 4'd9;
    bus.req_x[15:12] = 4'd2;  bus.req_y[15:12] = 4'd11;
    bus.req_valid    = 4'b1010;
    bus.rsp_ready    = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      er = (c % 2 == 0) ? 4'b0010 : 4'b1000;
      checks++;
      if (bus.req_ready !== er) begin errors++; $display("FAIL fair_grant c=%0d: got %b, required %b", c, bus.req_ready, er); end
      advance();
      bus.req_valid = 4'b1010;
    end
    bus.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] er;
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[4*i +: 4] = 4'(i + 2);
      bus.req_y[4*i +: 4] = 4'(i + 5);
    end
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c <= 6) begin
        er = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : (c == 6) ? 4'b0100 : 4'b0000;
        checks++;
        if (bus.req_ready !== er) begin errors++; $display("FAIL bp_grant c=%0d: got %b, required %b", c, bus.req_ready, er); end
      end
      if (c >= 2 && c <= 6) begin
        checks += 3;
        if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c=%0d: got %b, required 1", c, bus.rsp_valid); end
        if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL bp_hold_id c=%0d: got %0d, required 0", c, bus.rsp_id); end
        if (bus.rsp_prod !== 8'd10) begin errors++; $display("FAIL bp_hold_prod c=%0d: got %0d, required 10", c, bus.rsp_prod); end
      end
      if (c == 7) begin
        checks += 2;
        if (bus.rsp_id !== 2'd1) begin errors++; $display("FAIL bp_drain_id: got %0d, required 1", bus.rsp_id); end
        if (bus.rsp_prod !== 8'd18) begin errors++; $display("FAIL bp_drain_prod: got %0d, required 18", bus.rsp_prod); end
      end
      if (c == 11) begin
        checks += 2;
        if (bus.ops_done !== 16'd4) begin errors++; $display("FAIL bp_ops_done: got %0d, required 4", bus.ops_done); end
        if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got rsp_valid=%b, required 0", bus.rsp_valid); end
      end
      advance();
      if (c == 5) bus.rsp_ready = 1'b1;
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x[4*i +: 4] = 4'(i + 1);
      bus.req_y[4*i +: 4] = 4'(i + 2);
    end
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      advance();
    end
    rst_n         = 1'b0;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset_ready: got %b, required 0000", bus.req_ready); end
    advance();
    rst_n         = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks += 3;
      if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_stale_rsp c=%0d: got %b, required 0", c, bus.rsp_valid); end
      if (bus.ops_done !== 16'd0) begin errors++; $display("FAIL mid_ops_done c=%0d: got %0d, required 0", c, bus.ops_done); end
      if (dbg_ptr !== 2'd0) begin errors++; $display("FAIL mid_rr_ptr c=%0d: got %0d, required 0", c, dbg_ptr); end
      advance();
    end
    bus.req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_regrant: got %b, required 0001", bus.req_ready); end
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      advance();
    end
  endtask

  task automatic test_exhaustive();
    int t;
    apply_reset();
    bus.rsp_ready = 1'b1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        bus.req_x[3:0]   = 4'(a);
        bus.req_y[3:0]   = 4'(b);
        bus.req_valid[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL exh_grant a=%0d b=%0d: got %b, required 0001", a, b, bus.req_ready); end
        advance();
      end
    end
    t = 0;
    while ((exp_q.size() != 0 || bus.rsp_valid) && t < 10) begin
      @(negedge clk);
      advance();
      t++;
    end
    @(negedge clk);
    checks += 2;
    if (exp_q.size() != 0) begin errors++; $display("FAIL exh_drain: got %0d pending, required 0", exp_q.size()); end
    if (bus.ops_done !== 16'd256) begin errors++; $display("FAIL exh_ops_done: got %0d, required 256", bus.ops_done); end
    advance();
  endtask

  task automatic test_random();
    int since[NREQ];
    int t;
    logic [NREQ-1:0] acc;
    apply_reset();
    for (int i = 0; i < NREQ; i++) since[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) begin
          bus.req_x[4*i +: 4] = 4'($urandom_range(0, 15));
          bus.req_y[4*i +: 4] = 4'($urandom_range(0, 15));
          bus.req_valid[i]    = 1'b1;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      if (acc != '0) begin
        for (int i = 0; i < NREQ; i++) begin
          if (acc[i]) begin
            checks++;
            if (since[i] >= NREQ) begin errors++; $display("FAIL rand_fairness req=%0d: got %0d prior accepts, required < %0d", i, since[i], NREQ); end
            since[i] = 0;
          end else if (bus.req_valid[i]) begin
            since[i]++;
          end
        end
      end
      advance();
    end
    bus.rsp_ready = 1'b1;
    t = 0;
    while ((bus.req_valid != '0 || exp_q.size() != 0 || bus.rsp_valid) && t < 50) begin
      @(negedge clk);
      advance();
      t++;
    end
    @(negedge clk);
    checks += 2;
    if (exp_q.size() != 0 || bus.req_valid != '0) begin errors++; $display("FAIL rand_drain: got %0d pending, valid=%b, required empty", exp_q.size(), bus.req_valid); end
    if (bus.ops_done !== 16'(exp_ops)) begin errors++; $display("FAIL rand_ops_done: got %0d, required %0d", bus.ops_done, exp_ops); end
    advance();
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_exhaustive();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
